rsa_cmd_dispatch: RTL and testbench
===================================

Name: rsa_cmd_dispatch

Overview:
Control front-end inside the RSA accelerator, directly downstream of the ARM command/data channels. Decodes 32-bit commands, captures 1024-bit operands into an operand bank, and launches the Montgomery-multiply or exponentiation core. Returns the core result over the outbound data channel and signals completion with a done/done_read handshake.

Parameters:
DATA_W, 1024, width of data channels, operand registers and result register
CNT_W, 32, width of the compute-cycle counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
arm_to_fpga_cmd  in  32  command word
arm_to_fpga_cmd_valid  in  1  command strobe
fpga_to_arm_done  out  1  command complete
fpga_to_arm_done_read  in  1  done acknowledge
arm_to_fpga_data_valid  in  1  inbound data valid
arm_to_fpga_data_ready  out  1  inbound data ready
arm_to_fpga_data  in  DATA_W  inbound data
fpga_to_arm_data_valid  out  1  outbound data valid
fpga_to_arm_data_ready  in  1  outbound data ready
fpga_to_arm_data  out  DATA_W  outbound data (= result register)
op_a, op_b, op_m  out  DATA_W each  Montgomery operands
exp_x, exp_e, exp_m, exp_rmod, exp_rsq  out  DATA_W each  exponentiation operands
mont_start  out  1  one-cycle start pulse, Montgomery core
exp_start  out  1  one-cycle start pulse, exponentiation core
core_clear  out  1  one-cycle core reset pulse
core_done  in  1  one-cycle completion pulse from the active core
core_result  in  DATA_W  core output, valid with core_done
cycle_count  out  CNT_W  cycles from start pulse to core_done for the last compute, saturating
leds  out  4  current state encoding

Behaviour:
- Commands: 0 READ_A, 1 READ_B, 2 READ_M, 3 COMPUTE_EXP, 4 COMPUTE_MONT, 5 READ_EXP_MOD, 6 READ_EXP_RMOD, 7 READ_EXP_RSQ, 8 READ_EXP_X, 9 READ_EXP_EXP, A WRITE, B RESET_MONT. Any other value is unknown.
- Reset: all outputs 0, all operand registers, result register and cycle_count 0, state IDLE.
- States: IDLE(0), RX(1), START(2), WAIT_CORE(3), TX(4), DONE(5), CLEAR(6). leds = state[3:0].
- IDLE: cmd_valid is sampled only here. READ_* -> RX; COMPUTE_* -> START; WRITE -> TX; RESET_MONT -> CLEAR; unknown -> DONE. The command is latched into the selection register.
- RX: data_ready=1. A transfer occurs on the edge where valid and ready are both high. The data is written to the selected register, then the block goes to DONE with data_ready=0 in that same next cycle.
- START: exactly one cycle. mont_start or exp_start is high according to the latched command. cycle_count is reset to 0. Next state is WAIT_CORE.
- WAIT_CORE: cycle_count increments each cycle and saturates at all-ones. On core_done, core_result is latched into the result register and the state moves to DONE. No timeout.
- CLEAR: core_clear=1 for one cycle, then DONE. Operand registers are untouched.
- TX: data_valid=1 and fpga_to_arm_data = result register. On the valid&ready edge the state moves to DONE. The result register is retained, so repeated WRITEs return the same value.
- DONE: done=1 and held until done_read is sampled high, then IDLE. done_read outside DONE is ignored.
- Latency: cmd_valid edge -> next cycle in the target state. A command followed only by done_read costs 2 cycles minimum.
- Boundaries:
  - cmd_valid outside IDLE is ignored and not queued.
  - core_done outside WAIT_CORE is ignored.
  - data_valid in IDLE is not consumed.
  - reset in any state returns to IDLE within one edge, drops every handshake output, and clears all registers.

Decomposition:
- Package rsa_cmd_pkg holds the CMD_* constants, the state enum and the operand-select encoding.
- One sub-module, rsa_operand_bank, holds the eight DATA_W registers. Its inputs are write-enable, select and data; its outputs are all eight registers. It resets synchronously.
- The FSM, result register and counter live in the top module.

Test Plan:
- Load 1024'h87b2…9589 into A, then read back via COMPUTE_MONT with a core model returning op_a: done after each load; WRITE returns 1024'h87b2…9589.
- COMPUTE_EXP with a core model asserting core_done 37 cycles after exp_start: exp_start pulses exactly 1 cycle; cycle_count=37; result latched; done held until done_read.
- Delay fpga_to_arm_data_ready 5 cycles in WRITE: data_valid stays high and data is stable for all 5 cycles; done rises on the cycle after the transfer.
- Pulse cmd_valid=1 with cmd=4 while in WAIT_CORE, and send cmd=32'h1F in IDLE: the first is ignored with no second start pulse; the second gives done with no register change.
- Assert reset in RX while data_valid=1: data_ready=0, operand bank all-zero, leds=0 the next cycle.
- RESET_MONT: core_clear high exactly 1 cycle; op_a/op_b/op_m are unchanged.

Source files
------------

// File: rtl/rsa_cmd_pkg.sv
package rsa_cmd_pkg;

  localparam logic [31:0] CMD_READ_A        = 32'h0;
  localparam logic [31:0] CMD_READ_B        = 32'h1;
  localparam logic [31:0] CMD_READ_M        = 32'h2;
  localparam logic [31:0] CMD_COMPUTE_EXP   = 32'h3;
  localparam logic [31:0] CMD_COMPUTE_MONT  = 32'h4;
  localparam logic [31:0] CMD_READ_EXP_MOD  = 32'h5;
  localparam logic [31:0] CMD_READ_EXP_RMOD = 32'h6;
  localparam logic [31:0] CMD_READ_EXP_RSQ  = 32'h7;
  localparam logic [31:0] CMD_READ_EXP_X    = 32'h8;
  localparam logic [31:0] CMD_READ_EXP_EXP  = 32'h9;
  localparam logic [31:0] CMD_WRITE         = 32'hA;
  localparam logic [31:0] CMD_RESET_MONT    = 32'hB;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX        = 4'd1,
    ST_START     = 4'd2,
    ST_WAIT_CORE = 4'd3,
    ST_TX        = 4'd4,
    ST_DONE      = 4'd5,
    ST_CLEAR     = 4'd6
  } state_e;

  typedef enum logic [2:0] {
    SEL_A        = 3'd0,
    SEL_B        = 3'd1,
    SEL_M        = 3'd2,
    SEL_EXP_MOD  = 3'd3,
    SEL_EXP_RMOD = 3'd4,
    SEL_EXP_RSQ  = 3'd5,
    SEL_EXP_X    = 3'd6,
    SEL_EXP_E    = 3'd7
  } opsel_e;

  function automatic opsel_e cmd_to_sel(input logic [31:0] cmd);
    opsel_e sel;
    sel = SEL_A;
    case (cmd)
      CMD_READ_A:        sel = SEL_A;
      CMD_READ_B:        sel = SEL_B;
      CMD_READ_M:        sel = SEL_M;
      CMD_READ_EXP_MOD:  sel = SEL_EXP_MOD;
      CMD_READ_EXP_RMOD: sel = SEL_EXP_RMOD;
      CMD_READ_EXP_RSQ:  sel = SEL_EXP_RSQ;
      CMD_READ_EXP_X:    sel = SEL_EXP_X;
      CMD_READ_EXP_EXP:  sel = SEL_EXP_E;
      default:           sel = SEL_A;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rsa_operand_bank.sv
module rsa_operand_bank
  import rsa_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = 1024
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [2:0]        sel_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [DATA_W-1:0] m_o,
  output logic [DATA_W-1:0] exp_mod_o,
  output logic [DATA_W-1:0] exp_rmod_o,
  output logic [DATA_W-1:0] exp_rsq_o,
  output logic [DATA_W-1:0] exp_x_o,
  output logic [DATA_W-1:0] exp_e_o
);

  logic [DATA_W-1:0] regs_q [8];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[sel_i] <= wdata_i;
    end
  end

  assign a_o        = regs_q[SEL_A];
  assign b_o        = regs_q[SEL_B];
  assign m_o        = regs_q[SEL_M];
  assign exp_mod_o  = regs_q[SEL_EXP_MOD];
  assign exp_rmod_o = regs_q[SEL_EXP_RMOD];
  assign exp_rsq_o  = regs_q[SEL_EXP_RSQ];
  assign exp_x_o    = regs_q[SEL_EXP_X];
  assign exp_e_o    = regs_q[SEL_EXP_E];

endmodule

// File: rtl/rsa_cmd_dispatch.sv
module rsa_cmd_dispatch
  import rsa_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] op_m,
  output logic [DATA_W-1:0] exp_x,
  output logic [DATA_W-1:0] exp_e,
  output logic [DATA_W-1:0] exp_m,
  output logic [DATA_W-1:0] exp_rmod,
  output logic [DATA_W-1:0] exp_rsq,
  output logic              mont_start,
  output logic              exp_start,
  output logic              core_clear,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [3:0]        leds
);

  state_e            state_q, state_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              bank_we;
  logic [2:0]        bank_sel;

  assign bank_sel = cmd_to_sel(cmd_q);

  rsa_operand_bank #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk        (clk),
    .reset_i    (reset),
    .we_i       (bank_we),
    .sel_i      (bank_sel),
    .wdata_i    (arm_to_fpga_data),
    .a_o        (op_a),
    .b_o        (op_b),
    .m_o        (op_m),
    .exp_mod_o  (exp_m),
    .exp_rmod_o (exp_rmod),
    .exp_rsq_o  (exp_rsq),
    .exp_x_o    (exp_x),
    .exp_e_o    (exp_e)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Handshake and pulse outputs are pure functions of the registered state,
  // so a synchronous reset drops all of them on the same edge.
  always_comb begin
    state_d                = state_q;
    cmd_d                  = cmd_q;
    cnt_d                  = cnt_q;
    result_d               = result_q;
    bank_we                = 1'b0;
    fpga_to_arm_done       = 1'b0;
    arm_to_fpga_data_ready = 1'b0;
    fpga_to_arm_data_valid = 1'b0;
    mont_start             = 1'b0;
    exp_start              = 1'b0;
    core_clear             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm_to_fpga_cmd_valid) begin
          cmd_d = arm_to_fpga_cmd;
          case (arm_to_fpga_cmd)
            CMD_READ_A, CMD_READ_B, CMD_READ_M,
            CMD_READ_EXP_MOD, CMD_READ_EXP_RMOD, CMD_READ_EXP_RSQ,
            CMD_READ_EXP_X, CMD_READ_EXP_EXP:     state_d = ST_RX;
            CMD_COMPUTE_EXP, CMD_COMPUTE_MONT:    state_d = ST_START;
            CMD_WRITE:                            state_d = ST_TX;
            CMD_RESET_MONT:                       state_d = ST_CLEAR;
            default:                              state_d = ST_DONE;
          endcase
        end
      end
      ST_RX: begin
        arm_to_fpga_data_ready = 1'b1;
        if (arm_to_fpga_data_valid) begin
          bank_we = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_START: begin
        mont_start = (cmd_q == CMD_COMPUTE_MONT);
        exp_start  = (cmd_q == CMD_COMPUTE_EXP);
        cnt_d      = '0;
        state_d    = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (core_done) begin
          result_d = core_result;
          state_d  = ST_DONE;
        end
      end
      ST_TX: begin
        fpga_to_arm_data_valid = 1'b1;
        if (fpga_to_arm_data_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        fpga_to_arm_done = 1'b1;
        if (fpga_to_arm_done_read) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        core_clear = 1'b1;
        state_d    = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fpga_to_arm_data = result_q;
  assign cycle_count      = cnt_q;
  assign leds             = state_q;

endmodule

// File: tb/tb_rsa_cmd_dispatch.sv
module tb_rsa_cmd_dispatch;

  localparam int unsigned DW = 1024;
  localparam int unsigned CW = 32;
  localparam logic [DW-1:0] A_VAL = {16'h87b2, {62{16'h5a3c}}, 16'h9589};
  localparam logic [DW-1:0] R2    = {8{128'hdead_beef_0123_4567_89ab_cdef_fedc_ba98}};
  localparam logic [DW-1:0] JUNK  = {32{32'hc0ff_ee11}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   cmd = '0;
  logic          cmd_valid = 1'b0;
  logic          done;
  logic          done_read = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [DW-1:0] op_a, op_b, op_m, exp_x, exp_e, exp_m, exp_rmod, exp_rsq;
  logic          mont_start, exp_start, core_clear;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_result = '0;
  logic [CW-1:0] cycle_count;
  logic [3:0]    leds;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] mdl [8];

  typedef struct {
    logic [31:0]   cmd;
    logic [DW-1:0] data;
    int unsigned   idx;
    logic [3:0]    exp_leds;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  rsa_cmd_dispatch #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .arm_to_fpga_cmd        (cmd),
    .arm_to_fpga_cmd_valid  (cmd_valid),
    .fpga_to_arm_done       (done),
    .fpga_to_arm_done_read  (done_read),
    .arm_to_fpga_data_valid (in_valid),
    .arm_to_fpga_data_ready (in_ready),
    .arm_to_fpga_data       (in_data),
    .fpga_to_arm_data_valid (out_valid),
    .fpga_to_arm_data_ready (out_ready),
    .fpga_to_arm_data       (out_data),
    .op_a                   (op_a),
    .op_b                   (op_b),
    .op_m                   (op_m),
    .exp_x                  (exp_x),
    .exp_e                  (exp_e),
    .exp_m                  (exp_m),
    .exp_rmod               (exp_rmod),
    .exp_rsq                (exp_rsq),
    .mont_start             (mont_start),
    .exp_start              (exp_start),
    .core_clear             (core_clear),
    .core_done              (core_done),
    .core_result            (core_result),
    .cycle_count            (cycle_count),
    .leds                   (leds)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got[127:0]=%h expected[127:0]=%h differing_bits=%0d",
               nm, act[127:0], exp[127:0], $countones(act ^ exp));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_op(input int unsigned i, output logic [DW-1:0] v);
    case (i)
      0: v = op_a;
      1: v = op_b;
      2: v = op_m;
      3: v = exp_m;
      4: v = exp_rmod;
      5: v = exp_rsq;
      6: v = exp_x;
      default: v = exp_e;
    endcase
  endtask

  task automatic check_bank(input string nm);
    logic [DW-1:0] v;
    for (int unsigned i = 0; i < 8; i++) begin
      get_op(i, v);
      chk($sformatf("%s_reg%0d", nm, i), v, mdl[i]);
    end
  endtask

  task automatic finish_done(input string nm);
    chk({nm, "_done"}, DW'(done), DW'(1));
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    chk({nm, "_idle_leds"}, DW'(leds), DW'(0));
    chk({nm, "_done_low"}, DW'(done), DW'(0));
  endtask

  initial begin
    int starts;

    vecs[0] = '{32'h0, A_VAL,                 0, 4'd1};
    vecs[1] = '{32'h1, {32{32'h1111_0001}},   1, 4'd1};
    vecs[2] = '{32'h2, {32{32'h2222_0002}},   2, 4'd1};
    vecs[3] = '{32'h5, {32{32'h3333_0005}},   3, 4'd1};
    vecs[4] = '{32'h6, {32{32'h4444_0006}},   4, 4'd1};
    vecs[5] = '{32'h7, {32{32'h5555_0007}},   5, 4'd1};
    vecs[6] = '{32'h8, {32{32'h6666_0008}},   6, 4'd1};
    vecs[7] = '{32'h9, {32{32'h7777_0009}},   7, 4'd1};
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_leds", DW'(leds), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_ready", DW'(in_ready), DW'(0));
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_starts", DW'({mont_start, exp_start, core_clear}), DW'(0));
    chk("rst_count", DW'(cycle_count), DW'(0));
    chk("rst_data", out_data, '0);
    check_bank("rst");

    // data_valid in IDLE is not consumed
    in_data  = JUNK;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("idle_data_ready", DW'(in_ready), DW'(0));
    check_bank("idle_data");

    // Table-driven operand loads
    for (int i = 0; i < 8; i++) begin
      send_cmd(vecs[i].cmd);
      chk($sformatf("ld%0d_leds", i), DW'(leds), DW'(vecs[i].exp_leds));
      chk($sformatf("ld%0d_ready", i), DW'(in_ready), DW'(1));
      in_data  = vecs[i].data;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      mdl[vecs[i].idx] = vecs[i].data;
      chk($sformatf("ld%0d_ready_low", i), DW'(in_ready), DW'(0));
      chk($sformatf("ld%0d_done_leds", i), DW'(leds), DW'(5));
      check_bank($sformatf("ld%0d", i));
      finish_done($sformatf("ld%0d", i));
    end

    // COMPUTE_MONT with core echoing op_a
    send_cmd(32'h4);
    chk("mont_leds_start", DW'(leds), DW'(2));
    chk("mont_start_hi", DW'(mont_start), DW'(1));
    chk("mont_exp_start_lo", DW'(exp_start), DW'(0));
    tick();
    chk("mont_start_lo", DW'(mont_start), DW'(0));
    chk("mont_leds_wait", DW'(leds), DW'(3));
    core_result = mdl[0];
    core_done   = 1'b1;
    tick();
    core_done = 1'b0;
    chk("mont_count", DW'(cycle_count), DW'(1));
    chk("mont_result", out_data, A_VAL);
    finish_done("mont");

    send_cmd(32'hA);
    chk("wr1_leds", DW'(leds), DW'(4));
    chk("wr1_valid", DW'(out_valid), DW'(1));
    chk("wr1_data", out_data, A_VAL);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("wr1_valid_lo", DW'(out_valid), DW'(0));
    finish_done("wr1");

    // core_done in IDLE ignored; repeated WRITE returns the same value
    core_result = JUNK;
    core_done   = 1'b1;
    tick();
    core_done = 1'b0;
    chk("stray_core_done_leds", DW'(leds), DW'(0));
    send_cmd(32'hA);
    chk("wr2_data", out_data, A_VAL);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    finish_done("wr2");

    // COMPUTE_EXP, core_done 37 cycles after exp_start, stray cmd in WAIT_CORE
    core_result = R2;
    send_cmd(32'h3);
    chk("exp_start_hi", DW'(exp_start), DW'(1));
    chk("exp_mont_lo", DW'(mont_start), DW'(0));
    tick();
    chk("exp_start_lo", DW'(exp_start), DW'(0));
    starts = 0;
    for (int k = 0; k < 36; k++) begin
      if (k == 10) begin
        cmd       = 32'h4;
        cmd_valid = 1'b1;
      end
      if (k == 11) cmd_valid = 1'b0;
      tick();
      if (mont_start || exp_start) starts++;
    end
    chk("exp_no_restart", DW'(starts), DW'(0));
    chk("exp_wait_leds", DW'(leds), DW'(3));
    chk("exp_wait_done", DW'(done), DW'(0));
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("exp_count", DW'(cycle_count), DW'(37));
    chk("exp_result", out_data, R2);
    repeat (3) tick();
    chk("exp_done_held", DW'(done), DW'(1));
    finish_done("exp");

    // WRITE with ready delayed 5 cycles
    send_cmd(32'hA);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrd_valid%0d", k), DW'(out_valid), DW'(1));
      chk($sformatf("wrd_data%0d", k), out_data, R2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("wrd_done_rise", DW'(done), DW'(1));
    chk("wrd_valid_lo", DW'(out_valid), DW'(0));
    finish_done("wrd");

    // Unknown commands
    send_cmd(32'h1F);
    chk("unk1f_leds", DW'(leds), DW'(5));
    check_bank("unk1f");
    finish_done("unk1f");
    send_cmd(32'h10);
    chk("unk10_leds", DW'(leds), DW'(5));
    check_bank("unk10");
    finish_done("unk10");
    send_cmd(32'hC);
    chk("unk0c_leds", DW'(leds), DW'(5));
    finish_done("unk0c");

    // RESET_MONT
    send_cmd(32'hB);
    chk("clr_hi", DW'(core_clear), DW'(1));
    chk("clr_leds", DW'(leds), DW'(6));
    tick();
    chk("clr_lo", DW'(core_clear), DW'(0));
    check_bank("clr");
    chk("clr_result_kept", out_data, R2);
    finish_done("clr");

    // Reset while in RX with data_valid high
    send_cmd(32'h1);
    chk("rrx_leds", DW'(leds), DW'(1));
    in_data  = JUNK;
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    chk("rrx_ready", DW'(in_ready), DW'(0));
    chk("rrx_leds0", DW'(leds), DW'(0));
    chk("rrx_count", DW'(cycle_count), DW'(0));
    chk("rrx_result", out_data, '0);
    check_bank("rrx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
